// File: rtl/prm_scan_pkg.sv
// Shared widths, latency/depth constants, FSM state and FIFO entry layout
// for the parameter-check scan controller.
package prm_scan_pkg;

    localparam int XYZ_W      = 12;
    localparam int RES_W      = 32;
    localparam int LAT        = 3;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [RES_W-1:0] res;
        logic [XYZ_W-1:0] xyz;
    } res_entry_t;

    localparam int ENTRY_W = $bits(res_entry_t);

endpackage

// File: rtl/prm_res_fifo.sv
// Small first-word-fall-through FIFO holding tagged check results.
// The head entry is visible on dout whenever empty is low.
module prm_res_fifo
    import prm_scan_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO lands only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/xyz_scan_ctrl.sv
// Sweeps a window of {x,y,z} addresses into the parameter-check stage, tags each
// returning result with its address and buffers the pairs for a valid/ready consumer.
module xyz_scan_ctrl
    import prm_scan_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       cfg_sel1,
    input  logic [7:0]       cfg_sel2,
    input  logic [XYZ_W-1:0] cfg_base,
    input  logic [XYZ_W:0]   cfg_count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       sel1,
    output logic [7:0]       sel2,
    output logic [XYZ_W-1:0] xyzInput,
    input  logic [RES_W-1:0] result_imp,
    output logic             res_valid,
    output logic [RES_W-1:0] res_data,
    output logic [XYZ_W-1:0] res_xyz,
    input  logic             res_ready
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = $clog2(FIFO_DEPTH + LAT) + 1;

    state_t           state_q, state_d;
    logic [1:0]       sel1_q, sel1_d;
    logic [7:0]       sel2_q, sel2_d;
    logic [XYZ_W-1:0] addr_q, addr_d;
    logic [XYZ_W-1:0] xyz_q, xyz_d;
    logic [XYZ_W:0]   remain_q, remain_d;
    logic [LAT-1:0]   pipe_vld_q;
    logic [XYZ_W-1:0] pipe_tag_q [LAT];

    logic             issue;
    logic             credit_ok;
    logic [CRD_W-1:0] inflight;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_empty;
    res_entry_t       push_entry;
    res_entry_t       head_entry;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CRD_W'(pipe_vld_q[i]);
        end
    end

    // Every address in flight already owns a FIFO slot, so the FIFO can never overflow.
    assign credit_ok = (CRD_W'(fifo_level) + inflight) < CRD_W'(FIFO_DEPTH);

    always_comb begin
        state_d  = state_q;
        sel1_d   = sel1_q;
        sel2_d   = sel2_q;
        addr_d   = addr_q;
        xyz_d    = xyz_q;
        remain_d = remain_q;
        issue    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel1_d   = cfg_sel1;
                    sel2_d   = cfg_sel2;
                    addr_d   = cfg_base;
                    remain_d = cfg_count;
                    state_d  = (cfg_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    xyz_d    = addr_q;
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == (XYZ_W+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight == '0) && fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            sel1_q     <= '0;
            sel2_q     <= '0;
            addr_q     <= '0;
            xyz_q      <= '0;
            remain_q   <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_tag_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sel1_q     <= sel1_d;
            sel2_q     <= sel2_d;
            addr_q     <= addr_d;
            xyz_q      <= xyz_d;
            remain_q   <= remain_d;
            pipe_vld_q <= {pipe_vld_q[LAT-2:0], issue};
            pipe_tag_q[0] <= addr_q;
            for (int i = 1; i < LAT; i++) begin
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    assign push_entry = '{res: result_imp, xyz: pipe_tag_q[LAT-1]};

    prm_res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (pipe_vld_q[LAT-1]),
        .pop   (res_ready),
        .din   (push_entry),
        .dout  (head_entry),
        .level (fifo_level),
        .empty (fifo_empty)
    );

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sel1      = sel1_q;
    assign sel2      = sel2_q;
    assign xyzInput  = xyz_q;
    assign res_valid = !fifo_empty;
    assign res_data  = head_entry.res;
    assign res_xyz   = head_entry.xyz;

endmodule
